// File: rtl/prbs_test_seq.sv
// Self-test sequencer for one PRBS generator/checker pair: settle, acquire lock,
// count mismatches over a fixed sample window, then latch a pass/fail result.
module prbs_test_seq #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_CYCLES   = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int TEST_LEN      = 65536,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             rx_valid,
  input  logic             rx_match,
  output logic             prbs_en,
  output logic             chk_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       state,
  output logic [3:0]       led
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOCK   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);
  localparam int TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SMP_W  = (TEST_LEN > 1) ? $clog2(TEST_LEN) : 1;

  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(TEST_LEN - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [SMP_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;

  logic rx_good, rx_bad, settle_last, lock_hit, lock_tmo, run_last;

  // Lock is declared on the sample that brings the good run to LOCK_CYCLES,
  // i.e. while the counter still holds LOCK_CYCLES-1.
  assign rx_good     = rx_valid && rx_match;
  assign rx_bad      = rx_valid && !rx_match;
  assign settle_last = (settle_cnt_q == SET_LAST);
  assign lock_hit    = rx_good && (good_cnt_q == GOOD_LAST);
  assign lock_tmo    = (tmo_cnt_q == TMO_LAST);
  assign run_last    = rx_valid && (smp_cnt_q == SMP_LAST);

  // NOTE: synchronous reset; every flop, counters included, clears together.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      good_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      err_cnt_q    <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      good_cnt_q   <= good_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      err_cnt_q    <= err_cnt_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  // Abort outranks everything; lock outranks timeout in the same cycle.
  always_comb begin
    // NOTE: default first so no path through the block leaves state_d unassigned (no latch).
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
        ST_SETTLE:        if (settle_last) state_d = ST_LOCK;
        ST_LOCK: begin
          if (lock_hit)      state_d = ST_RUN;
          else if (lock_tmo) state_d = ST_DONE;
        end
        ST_RUN:           if (run_last) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    settle_cnt_d = settle_cnt_q;
    good_cnt_d   = good_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    if (abort) begin
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            settle_cnt_d = '0;
            good_cnt_d   = '0;
            tmo_cnt_d    = '0;
            smp_cnt_d    = '0;
            err_cnt_d    = '0;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
          end
        end
        ST_SETTLE: settle_cnt_d = settle_cnt_q + 1'b1;
        ST_LOCK: begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (rx_good)     good_cnt_d = good_cnt_q + 1'b1;
          else if (rx_bad) good_cnt_d = '0;
          if (!lock_hit && lock_tmo) begin
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (rx_valid) smp_cnt_d = smp_cnt_q + 1'b1;
          if (rx_bad && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
          // The final sample's own error counts toward the verdict.
          if (run_last) pass_d = (err_cnt_q == '0) && rx_match;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prbs_en = (state_q == ST_SETTLE) || (state_q == ST_LOCK) || (state_q == ST_RUN);
    chk_en  = (state_q == ST_LOCK) || (state_q == ST_RUN);
    busy    = prbs_en;
    done    = (state_q == ST_DONE);
    pass    = pass_q;
    timeout = timeout_q;
    err_cnt = err_cnt_q;
    state   = state_q;
    led     = {timeout_q, done && !pass_q, done && pass_q, busy};
  end

endmodule

// File: tb/tb_prbs_test_seq.sv
// Scenario bench for prbs_test_seq: each task drives one test-plan scenario, pushes
// the expected end-of-test outcome to a queue and compares it when the DUT responds.
module tb_prbs_test_seq;

  localparam int SETTLE = 4;
  localparam int LOCKC  = 3;
  localparam int TMO    = 20;
  localparam int TLEN   = 10;
  localparam int EW     = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_LOCK = 3'd2,
                         S_RUN = 3'd3, S_DONE = 3'd4;

  logic clk = 1'b0;
  logic rst, start, abort, rx_valid, rx_match;
  logic prbs_en, chk_en, busy, done, pass, timeout;
  logic [EW-1:0] err_cnt;
  logic [2:0] state;
  logic [3:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [11:0] snap_t;  // {state, err_cnt, pass, timeout, done, led}
  typedef struct {
    string name;
    snap_t v;
  } exp_t;
  exp_t exp_q[$];

  prbs_test_seq #(
    .SETTLE_CYCLES(SETTLE), .LOCK_CYCLES(LOCKC), .LOCK_TIMEOUT(TMO),
    .TEST_LEN(TLEN), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rx_valid(rx_valid), .rx_match(rx_match),
    .prbs_en(prbs_en), .chk_en(chk_en), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .state(state), .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic snap_t snap();
    return {state, err_cnt, pass, timeout, done, led};
  endfunction

  function automatic snap_t mk(logic [2:0] st, logic [1:0] e, logic p, logic t,
                               logic d, logic [3:0] l);
    return {st, e, p, t, d, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input snap_t v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  // Counts cycles spent in st, bounded by budget.
  task automatic measure(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (state === st && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_match = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({prbs_en, chk_en, busy, snap()} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", {prbs_en, chk_en, busy, snap()});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_run();
    exp_t e;
    int n;
    rx_valid = 1'b1; rx_match = 1'b1;
    push("clean_result", mk(S_DONE, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0010));
    pulse_start();
    n_checks++;
    if ({state, prbs_en, chk_en, busy} !== {S_SETTLE, 3'b101}) begin
      n_fail++;
      $display("FAIL clean_settle_enables: got %b expected %b", {state, prbs_en, chk_en, busy}, {S_SETTLE, 3'b101});
    end
    measure(S_SETTLE, 50, n);
    n_checks++;
    if (n != SETTLE) begin n_fail++; $display("FAIL clean_settle_len: got %0d expected %0d", n, SETTLE); end
    n_checks++;
    if ({state, prbs_en, chk_en, busy} !== {S_LOCK, 3'b111}) begin
      n_fail++;
      $display("FAIL clean_lock_enables: got %b expected %b", {state, prbs_en, chk_en, busy}, {S_LOCK, 3'b111});
    end
    measure(S_LOCK, 50, n);
    n_checks++;
    if (n != LOCKC) begin n_fail++; $display("FAIL clean_lock_len: got %0d expected %0d", n, LOCKC); end
    measure(S_RUN, 50, n);
    n_checks++;
    if (n != TLEN) begin n_fail++; $display("FAIL clean_run_len: got %0d expected %0d", n, TLEN); end
    e = exp_q.pop_front();
    n_checks++;
    if (snap() !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, snap(), e.v); end
  endtask

  task automatic test_lock_restart();
    exp_t e;
    int n;
    int entered;
    logic [5:0] pat;
    pat = 6'b111011;  // sample order from bit 0: good, good, bad, good, good, good
    rx_valid = 1'b1; rx_match = 1'b1;
    push("restart_result", mk(S_DONE, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0010));
    pulse_start();
    measure(S_SETTLE, 50, n);
    entered = 0;
    for (int i = 0; i < 6; i++) begin
      rx_match = pat[i];
      tick();
      if (state === S_RUN && entered == 0) entered = i + 1;
    end
    n_checks++;
    if (entered != 6) begin n_fail++; $display("FAIL restart_lock_sample: got %0d expected 6", entered); end
    rx_match = 1'b1;
    measure(S_RUN, 50, n);
    e = exp_q.pop_front();
    n_checks++;
    if (snap() !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, snap(), e.v); end
  endtask

  task automatic test_lock_timeout();
    exp_t e;
    int n;
    rx_valid = 1'b1; rx_match = 1'b1;
    push("timeout_result", mk(S_DONE, 2'd0, 1'b0, 1'b1, 1'b1, 4'b1100));
    pulse_start();
    measure(S_SETTLE, 50, n);
    rx_match = 1'b0;
    measure(S_LOCK, 100, n);
    n_checks++;
    if (n != TMO) begin n_fail++; $display("FAIL timeout_lock_len: got %0d expected %0d", n, TMO); end
    e = exp_q.pop_front();
    n_checks++;
    if (snap() !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, snap(), e.v); end
  endtask

  task automatic test_err_saturation();
    exp_t e;
    int n;
    int run_cyc;
    logic [9:0] bad;
    bad = 10'b1010101010;  // mismatches on samples 2,4,6,8,10
    rx_valid = 1'b1; rx_match = 1'b1;
    push("sat_result", mk(S_DONE, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100));
    pulse_start();
    measure(S_SETTLE, 50, n);
    measure(S_LOCK, 50, n);
    run_cyc = 0;
    for (int i = 0; i < TLEN; i++) begin
      rx_match = !bad[i];
      tick();
      if (state === S_RUN) run_cyc++;
      if (i == 5) begin
        n_checks++;
        if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_mid_err: got %0d expected 3", err_cnt); end
      end
    end
    n_checks++;
    if (run_cyc != TLEN - 1) begin n_fail++; $display("FAIL sat_run_len: got %0d expected %0d", run_cyc, TLEN - 1); end
    e = exp_q.pop_front();
    n_checks++;
    if (snap() !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, snap(), e.v); end
  endtask

  task automatic test_gapped_valid();
    exp_t e;
    int n;
    rx_valid = 1'b1; rx_match = 1'b1;
    push("gapped_result", mk(S_DONE, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0010));
    pulse_start();
    measure(S_SETTLE, 50, n);
    measure(S_LOCK, 50, n);
    n = 0;
    while (state === S_RUN && n < 40) begin
      rx_valid = n[0];
      rx_match = n[0];
      tick();
      n++;
    end
    n_checks++;
    if (n != 2 * TLEN) begin n_fail++; $display("FAIL gapped_run_len: got %0d expected %0d", n, 2 * TLEN); end
    e = exp_q.pop_front();
    n_checks++;
    if (snap() !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, snap(), e.v); end
  endtask

  task automatic test_abort_start_races();
    exp_t e;
    int n;
    rx_valid = 1'b1; rx_match = 1'b1;
    pulse_start();  // from DONE with pass=1
    n_checks++;
    if ({state, pass, done} !== {S_SETTLE, 2'b00}) begin
      n_fail++;
      $display("FAIL race_start_in_done: got %b expected %b", {state, pass, done}, {S_SETTLE, 2'b00});
    end
    measure(S_SETTLE, 50, n);
    measure(S_LOCK, 50, n);
    rx_match = 1'b0;
    tick();
    tick();
    n_checks++;
    if (err_cnt !== 2'd2) begin n_fail++; $display("FAIL race_err_two: got %0d expected 2", err_cnt); end
    rx_match = 1'b1;
    pulse_start();
    n_checks++;
    if ({state, err_cnt} !== {S_RUN, 2'd2}) begin
      n_fail++;
      $display("FAIL race_start_in_run: got %b expected %b", {state, err_cnt}, {S_RUN, 2'd2});
    end
    push("race_abort_with_start", mk(S_IDLE, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000));
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (snap() !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.name, snap(), e.v); end
    pulse_start();  // from IDLE with err_cnt held at 2
    n_checks++;
    if ({state, err_cnt} !== {S_SETTLE, 2'd0}) begin
      n_fail++;
      $display("FAIL race_start_clears_err: got %b expected %b", {state, err_cnt}, {S_SETTLE, 2'd0});
    end
    measure(S_SETTLE, 50, n);
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({prbs_en, chk_en, busy, snap()} !== 15'd0) begin
      n_fail++;
      $display("FAIL race_rst_in_lock: got %b expected all zero", {prbs_en, chk_en, busy, snap()});
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_lock_restart();
    test_lock_timeout();
    test_err_saturation();
    test_gapped_valid();
    test_abort_start_races();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_test_seq.md
Name: prbs_test_seq

Overview:
Sequencer for one PRBS link/LED self-test. On start it enables the PRBS generator and waits a fixed settle time. It then enables the checker, waits for a run of consecutive good samples (lock), counts mismatches over a fixed sample window, and latches a pass/fail result. The result drives status LEDs. It sits between the top-level test/start logic and the PRBS generator/checker pair, and owns their enables.

Parameters:
SETTLE_CYCLES, 16, cycles in SETTLE before the checker is enabled (>=1)
LOCK_CYCLES, 8, consecutive valid matching samples required to declare lock (>=1)
LOCK_TIMEOUT, 1024, max cycles in LOCK before giving up (>=1)
TEST_LEN, 65536, valid samples counted in RUN (>=1)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a test; honoured only in IDLE or DONE
abort  in  1  return to IDLE from any state
rx_valid  in  1  checker sample valid this cycle
rx_match  in  1  checker sample matched expected PRBS; qualified by rx_valid
prbs_en  out  1  PRBS generator enable
chk_en  out  1  checker enable
busy  out  1  high in SETTLE, LOCK, RUN
done  out  1  high in DONE
pass  out  1  result; meaningful only when done=1
timeout  out  1  lock timeout occurred in the last test
err_cnt  out  ERR_W  mismatches counted in RUN; saturating
state  out  3  IDLE=0, SETTLE=1, LOCK=2, RUN=3, DONE=4
led  out  4  [0]=busy, [1]=done&pass, [2]=done&!pass, [3]=timeout

Behaviour:
- Reset: state=IDLE. All outputs are 0, including err_cnt. All internal counters are 0.
- All outputs are registered or decoded from the registered state; there is no combinational path from an input to an output.
- IDLE or DONE with start=1 and abort=0: next state is SETTLE. On that transition err_cnt, pass, timeout and all internal counters clear to 0.
- prbs_en=1 in SETTLE, LOCK and RUN. chk_en=1 in LOCK and RUN.
- SETTLE: a cycle counter increments every cycle. When it equals SETTLE_CYCLES-1 the next state is LOCK, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- LOCK:
  - good-run counter: +1 on rx_valid&rx_match; cleared to 0 on rx_valid&!rx_match; held when rx_valid=0.
  - When the counter reaches LOCK_CYCLES (the cycle of the LOCK_CYCLES-th consecutive good sample), the next state is RUN.
  - A timeout counter increments every LOCK cycle. On the LOCK_TIMEOUT-th cycle without lock, the next state is DONE with pass=0 and timeout=1.
  - If lock and timeout occur in the same cycle, lock wins.
- RUN:
  - Each rx_valid cycle increments the sample counter.
  - rx_valid&!rx_match increments err_cnt. err_cnt saturates at 2^ERR_W-1 and never wraps.
  - The cycle carrying the TEST_LEN-th valid sample is counted, including its error, and the next state is DONE.
  - pass = 1 if the final err_cnt including that last sample is 0.
- DONE: done=1. pass, timeout and err_cnt hold until the next start or reset.
- abort=1 in any state (including simultaneously with start): next state is IDLE. pass, done and timeout go to 0; err_cnt holds its value.
- start in SETTLE, LOCK or RUN is ignored.
- rst asserted mid-test: the next cycle shows exactly the reset values.
- Internal counter widths are sized with $clog2 of their limit. The sample counter has no wrap-around before TEST_LEN.

Test Plan:
(Params for all scenarios: SETTLE=4, LOCK=3, TIMEOUT=20, TEST_LEN=10, ERR_W=2.)
- Clean run: pulse start with rx_valid=rx_match=1 constant -> SETTLE for 4 cycles, then LOCK for 3 cycles, then RUN for 10 cycles, then DONE. Result: pass=1, err_cnt=0, led=4'b0010.
- Lock restart: in LOCK drive samples good,good,bad,good,good,good -> RUN is entered only after the 6th sample. timeout=0.
- Lock timeout: rx_match=0 throughout LOCK -> DONE after exactly 20 LOCK cycles. Result: pass=0, timeout=1, led=4'b1100.
- Error saturation: 5 mismatches in RUN, including one on the 10th sample -> err_cnt=3 (saturated), pass=0, DONE entered after the 10th valid sample.
- Gapped valid: rx_valid toggling 1/0 in RUN -> RUN lasts 20 cycles (10 valid samples). Samples with rx_valid=0 and rx_match=0 are not counted as errors.
- Abort/start races: abort with start in RUN -> IDLE, err_cnt held. start in RUN is ignored. start in DONE -> SETTLE with err_cnt=0 and pass=0. rst in LOCK -> all outputs 0 on the next cycle.
